// File: rtl/alu_pkg.sv
// Shared ALU types: the one opcode definition and the arbiter FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RSP  = 2'd2
    } alu_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    int   cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx_o = cand[IDX_W-1:0];
            end
        end
        if (en_i && found) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters; one operation in flight,
// accept -> EXEC (ALU sampled) -> RSP (held until rsp_ready).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      rsp_c_o,
    output logic [IDX_W-1:0]          rsp_id_o,
    output logic [DATA_W-1:0]         alu_a_o,
    output logic [DATA_W-1:0]         alu_b_o,
    output logic [OP_W-1:0]           alu_op_o,
    input  logic [DATA_W-1:0]         alu_out_i,
    input  logic                      alu_c_i
);

    alu_arb_state_e    state_q;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  pend_id_q;
    logic [IDX_W-1:0]  gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic              win, accept;

    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_c_q;
    logic [IDX_W-1:0]  rsp_id_q;

    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];
    logic [OP_W-1:0]   op_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a_i[i*DATA_W +: DATA_W];
        assign b_arr[i]  = req_b_i[i*DATA_W +: DATA_W];
        assign op_arr[i] = req_op_i[i*OP_W +: OP_W];
    end

    // Window opens in IDLE, or in RSP on the cycle the response drains; held shut in reset.
    assign win = rst_ni && ((state_q == IDLE) || ((state_q == RSP) && rsp_ready_i));

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .en_i  (win),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign accept      = |gnt;
    assign req_ready_o = gnt;
    assign ptr_d       = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);

    assign rsp_valid_o = (state_q == RSP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_c_o     = rsp_c_q;
    assign rsp_id_o    = rsp_id_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            pend_id_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_c_q    <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            if (accept) begin
                alu_a_q   <= a_arr[gnt_idx];
                alu_b_q   <= b_arr[gnt_idx];
                alu_op_q  <= op_arr[gnt_idx];
                pend_id_q <= gnt_idx;
                ptr_q     <= ptr_d;
            end
            case (state_q)
                IDLE: if (accept) state_q <= EXEC;
                EXEC: begin
                    rsp_data_q <= alu_out_i;
                    rsp_c_q    <= alu_c_i;
                    rsp_id_q   <= pend_id_q;
                    state_q    <= RSP;
                end
                RSP:  if (rsp_ready_i) state_q <= accept ? EXEC : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, cycle model + response scoreboard, directed and soak phases.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*OW-1:0] req_op;
    logic            rsp_valid, rsp_ready, rsp_c;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   alu_a, alu_b, alu_out;
    logic [OW-1:0]   alu_op;
    logic            alu_c;

    always #5 clk_i = ~clk_i;

    alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_c_o(rsp_c), .rsp_id_o(rsp_id),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_out_i(alu_out), .alu_c_i(alu_c)
    );

    // ALU: c is carry for ADD, borrow for SUB, 0 for logic ops
    function automatic logic [8:0] ref_alu(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            ADD:     return {1'b0, a} + {1'b0, b};
            SUB:     return {1'b0, a} - {1'b0, b};
            AND:     return {1'b0, a & b};
            OR:      return {1'b0, a | b};
            XOR:     return {1'b0, a ^ b};
            default: return 9'h0;
        endcase
    endfunction

    always_comb {alu_c, alu_out} = ref_alu(alu_op, alu_a, alu_b);

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_ref(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int oh2idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct { logic [7:0] d; logic c; logic [1:0] id; } exp_t;

    exp_t           sbq[$];
    int             glog[$];
    int             rlog[$];
    alu_arb_state_e m_st = IDLE;
    int             m_ptr = 0;
    int             waitc [N];
    logic [N-1:0]   last_acc = '0;
    logic           m_win;
    int             m_g;
    logic [N-1:0]   exp_rdy;
    logic [8:0]     r;

    // Cycle model and scoreboard, sampled mid-cycle
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_st = IDLE; m_ptr = 0; sbq.delete(); last_acc = '0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else begin
            m_win = (m_st == IDLE) || (m_st == RSP && rsp_ready);
            m_g   = rr_ref(req_valid, m_ptr);
            exp_rdy = '0;
            if (m_win && m_g >= 0) exp_rdy[m_g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, m_st == RSP);
            if (m_st == RSP) begin
                chk("sb_depth", sbq.size(), 1);
                if (sbq.size() > 0) begin
                    chk("rsp_data", rsp_data, sbq[0].d);
                    chk("rsp_c", rsp_c, sbq[0].c);
                    chk("rsp_id", rsp_id, sbq[0].id);
                    if (rsp_ready) begin
                        rlog.push_back(int'(rsp_id));
                        void'(sbq.pop_front());
                    end
                end
            end
            last_acc = req_ready & req_valid;
            if (last_acc != '0) glog.push_back(oh2idx(last_acc));
            if (m_win && m_g >= 0) begin
                r = ref_alu(req_op[m_g*OW +: OW], req_a[m_g*DW +: DW], req_b[m_g*DW +: DW]);
                sbq.push_back('{d: r[7:0], c: r[8], id: 2'(m_g)});
                chk("starve", waitc[m_g] < N, 1);
                for (int i = 0; i < N; i++)
                    if (i != m_g && req_valid[i]) waitc[i]++;
                waitc[m_g] = 0;
                m_ptr = (m_g + 1) % N;
            end
            case (m_st)
                IDLE:    if (m_win && m_g >= 0) m_st = EXEC;
                EXEC:    m_st = RSP;
                default: if (rsp_ready) m_st = (m_g >= 0) ? EXEC : IDLE;
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid[i]        = v;
        req_op[i*OW +: OW]  = op;
        req_a[i*DW +: DW]   = a;
        req_b[i*DW +: DW]   = b;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},   req_ready, 0);
        chk({tag, "_rv"},    rsp_valid, 0);
        chk({tag, "_rdata"}, rsp_data, 0);
        chk({tag, "_rc"},    rsp_c, 0);
        chk({tag, "_rid"},   rsp_id, 0);
        chk({tag, "_alu"},   {alu_a, alu_b, 5'(alu_op)}, 0);
    endtask

    logic done;

    initial begin
        rst_ni = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        #1;
        chk_reset_outs("reset");
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);

        // Single request: F0 + 20 -> 10 with carry, two cycles after accept
        set_req(0, 1'b1, ADD, 8'hF0, 8'h20);
        @(negedge clk_i);
        chk("single_rdy", req_ready, 4'b0001);
        @(posedge clk_i); #1;
        req_valid = '0;
        cyc(1);
        @(negedge clk_i);
        chk("single_rv", rsp_valid, 1);
        chk("single_data", rsp_data, 8'h10);
        chk("single_c", rsp_c, 1);
        chk("single_id", rsp_id, 0);
        cyc(3);

        // All four continuously valid from pointer 0
        do_reset();
        set_req(0, 1'b1, ADD, 8'h11, 8'h22);
        set_req(1, 1'b1, SUB, 8'h10, 8'h20);
        set_req(2, 1'b1, XOR, 8'hAA, 8'h0F);
        set_req(3, 1'b1, OR,  8'h81, 8'h18);
        glog.delete(); rlog.delete();
        cyc(9);
        req_valid = '0;
        cyc(4);
        chk("rr_n", glog.size(), 5);
        chk("rr_n_rsp", rlog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < glog.size()) chk("rr_grant", glog[k], k % N);
            if (k < rlog.size()) chk("rr_rspid", rlog[k], k % N);
        end

        // Wrap: grant 3, then only 1 and 2 competing
        glog.delete();
        set_req(3, 1'b1, AND, 8'h3C, 8'hF0);
        cyc(1);
        req_valid = '0;
        set_req(1, 1'b1, ADD, 8'h01, 8'h02);
        set_req(2, 1'b1, SUB, 8'h09, 8'h03);
        cyc(4);
        req_valid = '0;
        cyc(4);
        chk("wrap_n", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("wrap_g0", glog[0], 3);
            chk("wrap_g1", glog[1], 1);
            chk("wrap_g2", glog[2], 2);
        end

        // Backpressure: response held, no accepts until rsp_ready returns
        rsp_ready = 1'b0;
        set_req(2, 1'b1, SUB, 8'h05, 8'h07);
        cyc(1);
        req_valid = '0;
        set_req(0, 1'b1, ADD, 8'h01, 8'h02);
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("bp_rv", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'hFE);
            chk("bp_id", rsp_id, 2);
            chk("bp_rdy", req_ready, 0);
            @(posedge clk_i); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk_i);
        chk("bp_resume", req_ready, 4'b0001);
        @(posedge clk_i); #1;
        req_valid = '0;
        cyc(3);

        // Reset while an AND is in EXEC
        set_req(1, 1'b1, AND, 8'h3C, 8'h0F);
        cyc(1);
        req_valid = '0;
        rst_ni = 1'b0;
        #1;
        chk_reset_outs("rst_exec");
        cyc(2);
        rst_ni = 1'b1;
        cyc(3);
        chk("rst_norsp", rsp_valid, 0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, XOR, 8'(i), 8'h55);
        @(negedge clk_i);
        chk("rst_first", req_ready, 4'b0001);
        @(posedge clk_i); #1;
        req_valid = '0;
        cyc(3);

        // Random soak: each requester holds its request until accepted
        for (int t = 0; t < 800; t++) begin
            req_valid = req_valid & ~last_acc;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(2) == 0)
                    set_req(i, 1'b1, 3'($urandom_range(4)), 8'($urandom), 8'($urandom));
            rsp_ready = ($urandom_range(3) != 0);
            cyc(1);
        end

        rsp_ready = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            req_valid = req_valid & ~last_acc;
            cyc(1);
            done = (req_valid == '0) && (m_st == IDLE) && (sbq.size() == 0);
        end
        chk("drain", done, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
